// File: rtl/ibuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ibuf_pkg
// Purpose : Shared constants and helpers for the instruction buffer:
//           default packet geometry, derived pointer/count widths and a
//           constant-foldable ceil(log2) function.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ibuf_pkg;

    // Ceiling log2 usable in parameter/localparam expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int IBUF_PKT_W  = 128;
    localparam int IBUF_BR_BIT = 100;

    localparam int DEF_FETCH_WIDTH    = 8;
    localparam int DEF_DISPATCH_WIDTH = 4;
    localparam int DEF_DEPTH          = 32;

    localparam int DEF_PTR_W = clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_PTR_W + 1;

endpackage
`default_nettype wire

// File: rtl/inst_buffer_param_if.sv
`default_nettype none
// ============================================================================
// Module  : inst_buffer_param_if
// Purpose : Bundles the decode-side write port, the dispatch-side read port
//           and the control inputs of the instruction buffer.
// Ports   : master - decode/backend side (drives *_i, observes *_o)
//           slave  - the buffer itself (observes *_i, drives *_o)
// Revision: 1.0 - initial release
// ============================================================================
interface inst_buffer_param_if #(
    parameter int FETCH_WIDTH    = ibuf_pkg::DEF_FETCH_WIDTH,
    parameter int DISPATCH_WIDTH = ibuf_pkg::DEF_DISPATCH_WIDTH,
    parameter int DEPTH          = ibuf_pkg::DEF_DEPTH,
    parameter int PKT_W          = ibuf_pkg::IBUF_PKT_W
);
    localparam int BC_W  = ibuf_pkg::clog2(DISPATCH_WIDTH + 1);
    localparam int CNT_W = ibuf_pkg::clog2(DEPTH) + 1;

    logic                            flush_i;
    logic                            stall_i;
    logic                            decodeReady_i;
    logic [FETCH_WIDTH-1:0]          decodedVector_i;
    logic [FETCH_WIDTH*PKT_W-1:0]    decodedPacket_i;
    logic                            stallFetch_o;
    logic                            instBufferReady_o;
    logic [DISPATCH_WIDTH-1:0]       dispatchVector_o;
    logic [DISPATCH_WIDTH*PKT_W-1:0] decodedPacket_o;
    logic [BC_W-1:0]                 branchCount_o;
    logic [CNT_W-1:0]                instCount_o;

    modport master (
        output flush_i, stall_i, decodeReady_i, decodedVector_i, decodedPacket_i,
        input  stallFetch_o, instBufferReady_o, dispatchVector_o, decodedPacket_o,
               branchCount_o, instCount_o
    );

    modport slave (
        input  flush_i, stall_i, decodeReady_i, decodedVector_i, decodedPacket_i,
        output stallFetch_o, instBufferReady_o, dispatchVector_o, decodedPacket_o,
               branchCount_o, instCount_o
    );

endinterface
`default_nettype wire

// File: rtl/inst_buffer_param_lane_compactor.sv
`default_nettype none
// ============================================================================
// Module  : lane_compactor
// Purpose : Exclusive prefix popcount over a sparse lane-valid vector. Lane k
//           is told how many valid lanes precede it, which is its offset from
//           the buffer tail, so sparse input lanes land contiguously.
// Ports   : vec_i    - per-lane valid
//           wr_en_i  - write accepted this cycle (gates the enables)
//           offset_o - per-lane write offset from the tail
//           en_o     - per-lane write enable
//           nIn_o    - number of valid lanes
// Revision: 1.0 - initial release
// ============================================================================
module lane_compactor #(
    parameter int FETCH_WIDTH = 8,
    parameter int OFF_W       = 4
) (
    input  wire logic [FETCH_WIDTH-1:0]            vec_i,
    input  wire logic                              wr_en_i,
    output logic      [FETCH_WIDTH-1:0][OFF_W-1:0] offset_o,
    output logic      [FETCH_WIDTH-1:0]            en_o,
    output logic      [OFF_W-1:0]                  nIn_o
);

    logic [OFF_W-1:0] w_run;

    always_comb begin
        w_run    = '0;
        offset_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            offset_o[k] = w_run;
            w_run       = w_run + OFF_W'(vec_i[k]);
        end
        nIn_o = w_run;
    end

    assign en_o = vec_i & {FETCH_WIDTH{wr_en_i}};

endmodule
`default_nettype wire

// File: rtl/inst_buffer_param.sv
`default_nettype none
// ============================================================================
// Module  : inst_buffer_param
// Purpose : Decoupling FIFO between decode and rename/dispatch. Accepts up to
//           FETCH_WIDTH sparse lanes per cycle, compacts them into contiguous
//           entries and presents up to DISPATCH_WIDTH oldest packets with a
//           per-lane valid vector, a branch count and the occupancy.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous active-high reset
//           bus   - slave side of inst_buffer_param_if (flush, stall, decode
//                   write port, dispatch read port, status)
// Revision: 1.0 - initial release
// ============================================================================
module inst_buffer_param
    import ibuf_pkg::*;
#(
    parameter int FETCH_WIDTH      = DEF_FETCH_WIDTH,
    parameter int DISPATCH_WIDTH   = DEF_DISPATCH_WIDTH,
    parameter int DEPTH            = DEF_DEPTH,        // power of two, >= FETCH_WIDTH + DISPATCH_WIDTH
    parameter int PKT_W            = IBUF_PKT_W,
    parameter int BR_BIT           = IBUF_BR_BIT,
    parameter int PARTIAL_DISPATCH = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    inst_buffer_param_if.slave bus
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = clog2(FETCH_WIDTH + 1);
    localparam int OUT_W = clog2(DISPATCH_WIDTH + 1);

    // ---------------- state ----------------
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];

    // ---------------- combinational ----------------
    logic                            w_stall_fetch;
    logic                            w_wr_en;
    logic                            w_ready;
    logic                            w_dispatch;
    logic [OUT_W-1:0]                w_avail;
    logic [OUT_W-1:0]                w_n_out;
    logic [OFF_W-1:0]                w_n_in;
    logic [FETCH_WIDTH-1:0]          w_lane_en;
    logic [FETCH_WIDTH-1:0][OFF_W-1:0] w_offset;
    logic [DISPATCH_WIDTH-1:0]       w_dv;
    logic [DISPATCH_WIDTH-1:0]       w_br;
    logic [OUT_W-1:0]                w_br_cnt;

    // Space check uses only the registered count and assumes no dispatch
    // credit, so a full FETCH_WIDTH write can never overflow.
    assign w_stall_fetch = (CNT_W'(DEPTH) - count_q) < CNT_W'(FETCH_WIDTH);
    assign w_wr_en       = bus.decodeReady_i & ~w_stall_fetch;

    lane_compactor #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .OFF_W       (OFF_W)
    ) u_compactor (
        .vec_i    (bus.decodedVector_i),
        .wr_en_i  (w_wr_en),
        .offset_o (w_offset),
        .en_o     (w_lane_en),
        .nIn_o    (w_n_in)
    );

    assign w_avail = (count_q >= CNT_W'(DISPATCH_WIDTH)) ? OUT_W'(DISPATCH_WIDTH)
                                                         : OUT_W'(count_q);

    generate
        if (PARTIAL_DISPATCH != 0) begin : g_partial
            assign w_ready = (count_q != '0);
            assign w_n_out = w_avail;
        end else begin : g_full_group
            assign w_ready = (count_q >= CNT_W'(DISPATCH_WIDTH));
            assign w_n_out = w_ready ? OUT_W'(DISPATCH_WIDTH) : '0;
        end
    endgenerate

    assign w_dispatch = w_ready & ~bus.stall_i;

    // Read ports: lane i shows entry head+i; the pointer add wraps modulo DEPTH.
    generate
        for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_read
            logic [PTR_W-1:0] w_rd_idx;
            assign w_rd_idx = head_q + PTR_W'(i);
            assign w_dv[i]  = (w_n_out > OUT_W'(i));
            assign w_br[i]  = w_dv[i] & mem_q[w_rd_idx][BR_BIT];
            assign bus.decodedPacket_o[i*PKT_W +: PKT_W] = mem_q[w_rd_idx];
        end
    endgenerate

    always_comb begin
        w_br_cnt = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            w_br_cnt = w_br_cnt + OUT_W'(w_br[i]);
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_wr_en) begin
                tail_d = tail_q + PTR_W'(w_n_in);
            end
            if (w_dispatch) begin
                head_d = head_q + PTR_W'(w_n_out);
            end
            count_d = count_q
                    + (w_wr_en    ? CNT_W'(w_n_in)  : '0)
                    - (w_dispatch ? CNT_W'(w_n_out) : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset. Writes during a flush or reset are harmless:
    // the pointers are cleared, so those entries are never presented.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (w_lane_en[k]) begin
                mem_q[tail_q + PTR_W'(w_offset[k])] <= bus.decodedPacket_i[k*PKT_W +: PKT_W];
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.stallFetch_o      = w_stall_fetch;
    assign bus.instBufferReady_o = w_ready;
    assign bus.dispatchVector_o  = w_dv;
    assign bus.branchCount_o     = w_br_cnt;
    assign bus.instCount_o       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_buffer_param
// Purpose : Self-checking bench for inst_buffer_param. A queue of packets in
//           age order is the reference; outputs are compared every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_buffer_param;
    import ibuf_pkg::*;

    localparam int FW    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 32;
    localparam int PW    = 128;
    localparam int BR    = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_buffer_param_if #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PW)) bus_p ();
    inst_buffer_param_if #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PW)) bus_f ();

    inst_buffer_param #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PW),
                        .BR_BIT(BR), .PARTIAL_DISPATCH(1)) u_dut_p (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_p.slave)
    );

    inst_buffer_param #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PW),
                        .BR_BIT(BR), .PARTIAL_DISPATCH(0)) u_dut_f (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] q [$];          // reference contents, oldest first
    logic [PW-1:0] pkt [FW];       // packets offered this cycle
    logic          cur_rdy, cur_stl, cur_fl;
    logic [FW-1:0] cur_vec;

    typedef struct {
        logic          rdy;
        logic [FW-1:0] vec;
        logic          stl;
        logic          fl;
        int            cnt;   // expected state seen before this row's edge
        logic          sf;
        logic          rd;
        logic [DW-1:0] dv;
        int            head;
        int            tail;
    } row_t;

    row_t tbl [15];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        int n, avail, bc;
        logic [DW-1:0] dv;
        n     = q.size();
        avail = (n < DW) ? n : DW;
        bc    = 0;
        dv    = '0;
        for (int i = 0; i < avail; i++) begin
            dv[i] = 1'b1;
            bc    = bc + int'(q[i][BR]);
        end
        chk("stallFetch",     PW'(bus_p.stallFetch_o),      PW'((DEPTH - n) < FW));
        chk("instBufferReady", PW'(bus_p.instBufferReady_o), PW'(n != 0));
        chk("dispatchVector", PW'(bus_p.dispatchVector_o),  PW'(dv));
        chk("branchCount",    PW'(bus_p.branchCount_o),     PW'(bc));
        chk("instCount",      PW'(bus_p.instCount_o),       PW'(n));
        for (int i = 0; i < avail; i++) begin
            chk("packet", bus_p.decodedPacket_o[i*PW +: PW], q[i]);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check outputs against
    // the reference before the next rising edge.
    task automatic apply(input logic rdy, input logic [FW-1:0] vec, input logic stl, input logic fl);
        @(negedge clk);
        cur_rdy = rdy; cur_vec = vec; cur_stl = stl; cur_fl = fl;
        bus_p.decodeReady_i   = rdy;
        bus_p.decodedVector_i = vec;
        bus_p.stall_i         = stl;
        bus_p.flush_i         = fl;
        for (int k = 0; k < FW; k++) begin
            pkt[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus_p.decodedPacket_i[k*PW +: PW] = pkt[k];
        end
        #1;
        check_model();
    endtask

    // Reference update for the edge that follows apply().
    task automatic advance();
        int n, avail;
        logic wr, disp;
        logic [PW-1:0] junk;
        n     = q.size();
        avail = (n < DW) ? n : DW;
        wr    = cur_rdy && ((DEPTH - n) >= FW);
        disp  = (n != 0) && !cur_stl;
        if (cur_fl) begin
            q.delete();
        end else begin
            if (disp) begin
                for (int i = 0; i < avail; i++) junk = q.pop_front();
            end
            if (wr) begin
                for (int k = 0; k < FW; k++) if (cur_vec[k]) q.push_back(pkt[k]);
            end
        end
    endtask

    task automatic step(input logic rdy, input logic [FW-1:0] vec, input logic stl, input logic fl);
        apply(rdy, vec, stl, fl);
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] first_f;
        int guard;

        bus_p.decodeReady_i = 1'b0; bus_p.decodedVector_i = '0; bus_p.decodedPacket_i = '0;
        bus_p.stall_i = 1'b0; bus_p.flush_i = 1'b0;
        bus_f.decodeReady_i = 1'b0; bus_f.decodedVector_i = '0; bus_f.decodedPacket_i = '0;
        bus_f.stall_i = 1'b1; bus_f.flush_i = 1'b0;

        //            rdy   vec    stl   fl    cnt sf    rd    dv     head tail
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0,  0, 1'b0, 1'b0, 4'h0,  0,  0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0,  4, 1'b0, 1'b1, 4'hF,  0,  4};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0,  4, 1'b0, 1'b1, 4'hF,  0,  4};
        tbl[3]  = '{1'b1, 8'h07, 1'b1, 1'b0,  0, 1'b0, 1'b0, 4'h0,  4,  4};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0,  3, 1'b0, 1'b1, 4'h7,  4,  7};
        tbl[5]  = '{1'b1, 8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0, 4'h0,  7,  7};
        tbl[6]  = '{1'b1, 8'hFF, 1'b1, 1'b0,  0, 1'b0, 1'b0, 4'h0,  7,  7};
        tbl[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0,  8, 1'b0, 1'b1, 4'hF,  7, 15};
        tbl[8]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 16, 1'b0, 1'b1, 4'hF,  7, 23};
        tbl[9]  = '{1'b1, 8'h01, 1'b1, 1'b0, 24, 1'b0, 1'b1, 4'hF,  7, 31};
        tbl[10] = '{1'b1, 8'hFF, 1'b1, 1'b0, 25, 1'b1, 1'b1, 4'hF,  7,  0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 25, 1'b1, 1'b1, 4'hF,  7,  0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 21, 1'b0, 1'b1, 4'hF, 11,  0};
        tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 17, 1'b0, 1'b1, 4'hF, 15,  0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0, 4'h0,  0,  0};

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed table: fixed expectations plus the reference checks.
        for (int r = 0; r < 15; r++) begin
            apply(tbl[r].rdy, tbl[r].vec, tbl[r].stl, tbl[r].fl);
            chk("tbl_instCount", PW'(bus_p.instCount_o),       PW'(tbl[r].cnt));
            chk("tbl_stallFetch", PW'(bus_p.stallFetch_o),     PW'(tbl[r].sf));
            chk("tbl_ready",     PW'(bus_p.instBufferReady_o), PW'(tbl[r].rd));
            chk("tbl_dispVec",   PW'(bus_p.dispatchVector_o),  PW'(tbl[r].dv));
            chk("tbl_headPtr",   PW'(u_dut_p.head_q),          PW'(tbl[r].head));
            chk("tbl_tailPtr",   PW'(u_dut_p.tail_q),          PW'(tbl[r].tail));
            advance();
        end

        // Move both pointers to 30, then write 8 and dispatch across the wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h3F, 1'b1, 1'b0);
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            guard++;
        end
        chk("drain_bound", PW'(q.size()), PW'(0));
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_headPtr", PW'(u_dut_p.head_q), PW'(30));
        chk("wrap_tailPtr", PW'(u_dut_p.tail_q), PW'(6));
        advance();
        apply(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("wrap_headPtr_after", PW'(u_dut_p.head_q), PW'(2));

        // Reset asserted mid-cycle aborts the pending write and dispatch.
        #2 reset = 1'b1;
        #1;
        chk("midreset_count", PW'(bus_p.instCount_o), PW'(0));
        chk("midreset_ready", PW'(bus_p.instBufferReady_o), PW'(0));
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        bus_p.decodeReady_i = 1'b0;
        bus_p.flush_i = 1'b0;

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, FW'($urandom()), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 40) == 0);
        end

        // Full-group-only instance.
        @(negedge clk);
        first_f = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus_f.decodedPacket_i = '0;
        bus_f.decodedPacket_i[PW +: PW] = first_f;   // lane 1 is the oldest valid lane
        bus_f.decodeReady_i = 1'b1; bus_f.decodedVector_i = 8'h0E; bus_f.stall_i = 1'b0;
        @(negedge clk);
        bus_f.decodeReady_i = 1'b0;
        #1;
        chk("full_count3", PW'(bus_f.instCount_o), PW'(3));
        chk("full_ready3", PW'(bus_f.instBufferReady_o), PW'(0));
        chk("full_dv3",    PW'(bus_f.dispatchVector_o), PW'(0));
        bus_f.decodeReady_i = 1'b1; bus_f.decodedVector_i = 8'h80;
        @(negedge clk);
        bus_f.decodeReady_i = 1'b0;
        #1;
        chk("full_count4", PW'(bus_f.instCount_o), PW'(4));
        chk("full_ready4", PW'(bus_f.instBufferReady_o), PW'(1));
        chk("full_dv4",    PW'(bus_f.dispatchVector_o), PW'(4'hF));
        chk("full_lane0",  bus_f.decodedPacket_o[PW-1:0], first_f);
        @(negedge clk);
        #1;
        chk("full_count0", PW'(bus_f.instCount_o), PW'(0));
        chk("full_ready0", PW'(bus_f.instBufferReady_o), PW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
